mdu_issue_ctrl: RTL

//  Issue/stall controller for the E-stage multiply-divide unit (MDU). It decides

---
 rtl/mdu_issue_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/mdu_issue_ctrl.sv
// Issue/stall controller for the E-stage MDU: Start pulse, busy window mirror, D-stage stall.
// Optional MDU_PERF_EN adds perf_issued/perf_stall event counters.
module mdu_issue_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             e_valid,
    input  logic [2:0]       e_op,
    input  logic             d_use_md,
    output logic             start,
    output logic             busy,
    output logic             stall,
    output logic [CNT_W-1:0] cycles_left,
    output logic             proto_err
`ifdef MDU_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_proto_err;
    logic             w_is_md;
    logic             w_is_mult;
    logic             w_any_op;
    logic             w_busy;
    logic             w_start;
    logic [CNT_W-1:0] w_lat;

    always_comb begin
        w_is_mult = (e_op == 3'd1) || (e_op == 3'd2);
        w_is_md   = (e_op >= 3'd1) && (e_op <= 3'd4);
        w_any_op  = (e_op != 3'd0);
        w_busy    = (r_state == ST_RUN);
        w_start   = (r_state == ST_IDLE) && e_valid && w_is_md && !req;
        w_lat     = w_is_mult ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= w_lat;
                    end
                end
                default: begin
                    // cnt==1 is the commit edge; counter lands on 0 with the return to IDLE
                    if (r_cnt > CNT_W'(1)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
            endcase
            if (w_busy && e_valid && w_any_op) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign start       = w_start;
    assign busy        = w_busy;
    assign stall       = d_use_md && (w_busy || w_start);
    assign cycles_left = r_cnt;
    assign proto_err   = r_proto_err;

`ifdef MDU_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_start) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif

endmodule
